// File: rtl/rename_unit.sv
// Register-rename stage: speculative/retirement alias tables, free-register vector
// and a one-deep output register. Flush restores the committed mapping in one cycle.
module rename_unit #(
  parameter int ARCH_ADDR_W = 5,
  parameter int PHYS_ADDR_W = 6,
  parameter int WIDTH       = 2,
  parameter int RETIRE      = 2
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic [WIDTH-1:0]               in_valid,
  input  logic [WIDTH-1:0]               in_has_rd,
  input  logic [WIDTH*ARCH_ADDR_W-1:0]   in_rs1,
  input  logic [WIDTH*ARCH_ADDR_W-1:0]   in_rs2,
  input  logic [WIDTH*ARCH_ADDR_W-1:0]   in_rd,
  output logic                           in_ready,
  output logic [WIDTH-1:0]               out_valid,
  output logic [WIDTH*PHYS_ADDR_W-1:0]   out_ps1,
  output logic [WIDTH*PHYS_ADDR_W-1:0]   out_ps2,
  output logic [WIDTH*PHYS_ADDR_W-1:0]   out_pd,
  output logic [WIDTH*PHYS_ADDR_W-1:0]   out_old_pd,
  input  logic                           out_ready,
  input  logic [RETIRE-1:0]              commit_valid,
  input  logic [RETIRE*ARCH_ADDR_W-1:0]  commit_rd,
  input  logic [RETIRE*PHYS_ADDR_W-1:0]  commit_pd,
  input  logic [RETIRE*PHYS_ADDR_W-1:0]  commit_old_pd,
  input  logic                           flush,
  output logic [PHYS_ADDR_W:0]           free_cnt
);

  localparam int NUM_ARCH = 2**ARCH_ADDR_W;
  localparam int NUM_PHYS = 2**PHYS_ADDR_W;
  localparam int CNT_W    = PHYS_ADDR_W + 1;
  localparam logic [NUM_PHYS-1:0] ONE_P     = {{(NUM_PHYS-1){1'b0}}, 1'b1};
  localparam logic [NUM_PHYS-1:0] FREE_RST  = {{(NUM_PHYS-NUM_ARCH){1'b1}}, {NUM_ARCH{1'b0}}};

  function automatic logic [ARCH_ADDR_W-1:0] arch_f(input logic [WIDTH*ARCH_ADDR_W-1:0] v, input int l);
    return v[l*ARCH_ADDR_W +: ARCH_ADDR_W];
  endfunction

  function automatic logic [PHYS_ADDR_W-1:0] lowest_set(input logic [NUM_PHYS-1:0] v);
    logic [PHYS_ADDR_W-1:0] r;
    r = '0;
    for (int i = NUM_PHYS-1; i >= 0; i--) r = v[i] ? PHYS_ADDR_W'(i) : r;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_PHYS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_PHYS; i++) c = c + CNT_W'(v[i]);
    return c;
  endfunction

  logic [PHYS_ADDR_W-1:0] spec_rat_q [NUM_ARCH];
  logic [PHYS_ADDR_W-1:0] spec_rat_d [NUM_ARCH];
  logic [PHYS_ADDR_W-1:0] ret_rat_q  [NUM_ARCH];
  logic [PHYS_ADDR_W-1:0] ret_rat_d  [NUM_ARCH];
  logic [NUM_PHYS-1:0]    free_q, free_d, avail_s, used_s;
  logic [CNT_W-1:0]       free_cnt_q, free_cnt_d;
  logic [WIDTH-1:0]       out_valid_q, out_valid_d, alloc_s;
  logic [WIDTH*PHYS_ADDR_W-1:0] out_ps1_q, out_ps1_d, out_ps2_q, out_ps2_d;
  logic [WIDTH*PHYS_ADDR_W-1:0] out_pd_q, out_pd_d, out_old_q, out_old_d;
  logic [PHYS_ADDR_W-1:0] pd_s [WIDTH];
  logic [PHYS_ADDR_W-1:0] ps1_s [WIDTH];
  logic [PHYS_ADDR_W-1:0] ps2_s [WIDTH];
  logic [PHYS_ADDR_W-1:0] old_s [WIDTH];
  logic in_ready_s, accept_s, out_load_s;

  // Ready never looks at in_valid, so upstream can depend on it combinationally.
  assign out_load_s = !(|out_valid_q) || out_ready;
  assign in_ready_s = !res && !flush && out_load_s && (free_cnt_q >= CNT_W'(WIDTH));
  assign accept_s   = in_ready_s && (|in_valid);

  // Allocation (lowest free first, lane order) and intra-group bypass of sources/old mapping.
  always_comb begin
    avail_s = free_q;
    for (int i = 0; i < WIDTH; i++) begin
      alloc_s[i] = in_valid[i] && in_has_rd[i] && (arch_f(in_rd, i) != '0);
      pd_s[i]    = alloc_s[i] ? lowest_set(avail_s) : '0;
      avail_s    = alloc_s[i] ? (avail_s & ~(ONE_P << pd_s[i])) : avail_s;
    end
    for (int j = 0; j < WIDTH; j++) begin
      ps1_s[j] = spec_rat_q[arch_f(in_rs1, j)];
      ps2_s[j] = spec_rat_q[arch_f(in_rs2, j)];
      old_s[j] = spec_rat_q[arch_f(in_rd, j)];
      for (int i = 0; i < j; i++) begin
        ps1_s[j] = (alloc_s[i] && arch_f(in_rd, i) == arch_f(in_rs1, j)) ? pd_s[i] : ps1_s[j];
        ps2_s[j] = (alloc_s[i] && arch_f(in_rd, i) == arch_f(in_rs2, j)) ? pd_s[i] : ps2_s[j];
        old_s[j] = (alloc_s[i] && arch_f(in_rd, i) == arch_f(in_rd, j))  ? pd_s[i] : old_s[j];
      end
      ps1_s[j] = (arch_f(in_rs1, j) == '0) ? '0 : ps1_s[j];
      ps2_s[j] = (arch_f(in_rs2, j) == '0) ? '0 : ps2_s[j];
      old_s[j] = alloc_s[j] ? old_s[j] : '0;
    end
  end

  // Alias tables and free vector: commits first, then flush rebuild or rename writes.
  always_comb begin
    ret_rat_d = ret_rat_q;
    free_d    = accept_s ? avail_s : free_q;
    for (int k = 0; k < RETIRE; k++) begin
      ret_rat_d[arch_f(commit_rd, k)] =
        (commit_valid[k] && arch_f(commit_rd, k) != '0) ? commit_pd[k*PHYS_ADDR_W +: PHYS_ADDR_W]
                                                        : ret_rat_d[arch_f(commit_rd, k)];
      free_d = (commit_valid[k] && commit_old_pd[k*PHYS_ADDR_W +: PHYS_ADDR_W] != '0)
               ? (free_d | (ONE_P << commit_old_pd[k*PHYS_ADDR_W +: PHYS_ADDR_W])) : free_d;
    end
    used_s = ONE_P;
    for (int a = 0; a < NUM_ARCH; a++) used_s[ret_rat_d[a]] = 1'b1;
    free_d = flush ? ~used_s : free_d;
    spec_rat_d = spec_rat_q;
    for (int i = 0; i < WIDTH; i++) begin
      spec_rat_d[arch_f(in_rd, i)] = (accept_s && alloc_s[i]) ? pd_s[i] : spec_rat_d[arch_f(in_rd, i)];
    end
    for (int a = 0; a < NUM_ARCH; a++) spec_rat_d[a] = flush ? ret_rat_d[a] : spec_rat_d[a];
    free_cnt_d = popcount(free_d);
  end

  // Output register: cleared on flush, loaded/cleared when free to move, else held.
  always_comb begin
    out_valid_d = out_valid_q;
    out_ps1_d   = out_ps1_q;
    out_ps2_d   = out_ps2_q;
    out_pd_d    = out_pd_q;
    out_old_d   = out_old_q;
    if (flush) begin
      out_valid_d = '0;
      out_ps1_d   = '0;
      out_ps2_d   = '0;
      out_pd_d    = '0;
      out_old_d   = '0;
    end else if (out_load_s) begin
      out_valid_d = accept_s ? in_valid : '0;
      for (int i = 0; i < WIDTH; i++) begin
        out_ps1_d[i*PHYS_ADDR_W +: PHYS_ADDR_W] = (accept_s && in_valid[i]) ? ps1_s[i] : '0;
        out_ps2_d[i*PHYS_ADDR_W +: PHYS_ADDR_W] = (accept_s && in_valid[i]) ? ps2_s[i] : '0;
        out_pd_d[i*PHYS_ADDR_W +: PHYS_ADDR_W]  = (accept_s && alloc_s[i])  ? pd_s[i]  : '0;
        out_old_d[i*PHYS_ADDR_W +: PHYS_ADDR_W] = (accept_s && alloc_s[i])  ? old_s[i] : '0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset to the identity mapping.
  always_ff @(posedge clk) begin
    if (res) begin
      for (int a = 0; a < NUM_ARCH; a++) begin
        spec_rat_q[a] <= PHYS_ADDR_W'(a);
        ret_rat_q[a]  <= PHYS_ADDR_W'(a);
      end
      free_q      <= FREE_RST;
      free_cnt_q  <= CNT_W'(NUM_PHYS - NUM_ARCH);
      out_valid_q <= '0;
      out_ps1_q   <= '0;
      out_ps2_q   <= '0;
      out_pd_q    <= '0;
      out_old_q   <= '0;
    end else begin
      spec_rat_q  <= spec_rat_d;
      ret_rat_q   <= ret_rat_d;
      free_q      <= free_d;
      free_cnt_q  <= free_cnt_d;
      out_valid_q <= out_valid_d;
      out_ps1_q   <= out_ps1_d;
      out_ps2_q   <= out_ps2_d;
      out_pd_q    <= out_pd_d;
      out_old_q   <= out_old_d;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = out_valid_q;
  assign out_ps1    = out_ps1_q;
  assign out_ps2    = out_ps2_q;
  assign out_pd     = out_pd_q;
  assign out_old_pd = out_old_q;
  assign free_cnt   = free_cnt_q;

endmodule

// File: tb/tb_rename_unit.sv
// Scoreboard bench for rename_unit: a reference model predicts each accepted group,
// plus directed checks of the concrete rename scenarios.
module tb_rename_unit;

  logic        clk = 1'b0;
  logic        res;
  logic [1:0]  in_valid, in_has_rd;
  logic [9:0]  in_rs1, in_rs2, in_rd;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [11:0] out_ps1, out_ps2, out_pd, out_old_pd;
  logic        out_ready;
  logic [1:0]  commit_valid;
  logic [9:0]  commit_rd;
  logic [11:0] commit_pd, commit_old_pd;
  logic        flush;
  logic [6:0]  free_cnt;

  rename_unit dut (
    .clk(clk), .res(res), .in_valid(in_valid), .in_has_rd(in_has_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_ready(in_ready),
    .out_valid(out_valid), .out_ps1(out_ps1), .out_ps2(out_ps2), .out_pd(out_pd),
    .out_old_pd(out_old_pd), .out_ready(out_ready), .commit_valid(commit_valid),
    .commit_rd(commit_rd), .commit_pd(commit_pd), .commit_old_pd(commit_old_pd),
    .flush(flush), .free_cnt(free_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  v;
    logic [11:0] ps1, ps2, pd, old;
  } grp_t;

  int   checks = 0;
  int   errors = 0;
  grp_t sb[$];
  int   m_spec[32];
  int   m_ret[32];
  bit   m_free[64];
  logic [1:0] m_ov;
  bit   cur_al[2];
  int   cur_pd[2];
  int   cur_rd[2];
  logic [11:0] snap;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_cnt();
    int c = 0;
    for (int p = 0; p < 64; p++) c += int'(m_free[p]);
    return c;
  endfunction

  function automatic int map_reg(input int lane, input int arch);
    int r = (arch == 0) ? 0 : m_spec[arch];
    for (int k = 0; k < lane; k++) if (cur_al[k] && cur_rd[k] == arch && arch != 0) r = cur_pd[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 32; a++) begin m_spec[a] = a; m_ret[a] = a; end
    for (int p = 0; p < 64; p++) m_free[p] = (p >= 32);
    m_ov = 2'b00;
    sb.delete();
  endtask

  task automatic clear_in();
    in_valid = 2'b00; in_has_rd = 2'b00; in_rs1 = 10'd0; in_rs2 = 10'd0; in_rd = 10'd0;
    commit_valid = 2'b00; commit_rd = 10'd0; commit_pd = 12'd0; commit_old_pd = 12'd0;
    flush = 1'b0;
  endtask

  task automatic set_lane(input int l, input bit h, input int s1, input int s2, input int d);
    in_valid[l] = 1'b1; in_has_rd[l] = h;
    in_rs1[l*5 +: 5] = 5'(s1); in_rs2[l*5 +: 5] = 5'(s2); in_rd[l*5 +: 5] = 5'(d);
  endtask

  task automatic set_commit(input int k, input int rd, input int pd, input int old);
    commit_valid[k] = 1'b1; commit_rd[k*5 +: 5] = 5'(rd);
    commit_pd[k*6 +: 6] = 6'(pd); commit_old_pd[k*6 +: 6] = 6'(old);
  endtask

  // One clock: predict, step, compare; returns at the following negedge.
  task automatic tick();
    bit   rdy, acc, loaded;
    bit   avail[64];
    grp_t g, got;
    #1;
    rdy = !res && !flush && !(m_ov != 2'b00 && !out_ready) && (m_cnt() >= 2);
    check_val("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    acc = rdy && (in_valid != 2'b00);
    g = '0;
    loaded = 1'b0;
    if (acc) begin
      avail = m_free;
      for (int i = 0; i < 2; i++) begin
        cur_rd[i] = int'(in_rd[i*5 +: 5]);
        cur_al[i] = in_valid[i] && in_has_rd[i] && cur_rd[i] != 0;
        cur_pd[i] = 0;
        if (cur_al[i]) begin
          for (int p = 63; p >= 1; p--) if (avail[p]) cur_pd[i] = p;
          avail[cur_pd[i]] = 1'b0;
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (in_valid[i]) begin
          g.v[i] = 1'b1;
          g.ps1[i*6 +: 6] = 6'(map_reg(i, int'(in_rs1[i*5 +: 5])));
          g.ps2[i*6 +: 6] = 6'(map_reg(i, int'(in_rs2[i*5 +: 5])));
          if (cur_al[i]) begin
            g.pd[i*6 +: 6]  = 6'(cur_pd[i]);
            g.old[i*6 +: 6] = 6'(map_reg(i, cur_rd[i]));
          end
        end
      end
      for (int i = 0; i < 2; i++) if (cur_al[i]) begin
        m_spec[cur_rd[i]] = cur_pd[i];
        m_free[cur_pd[i]] = 1'b0;
      end
    end
    for (int k = 0; k < 2; k++) if (commit_valid[k]) begin
      if (commit_rd[k*5 +: 5] != 5'd0) m_ret[int'(commit_rd[k*5 +: 5])] = int'(commit_pd[k*6 +: 6]);
      if (commit_old_pd[k*6 +: 6] != 6'd0) m_free[int'(commit_old_pd[k*6 +: 6])] = 1'b1;
    end
    if (flush) begin
      for (int p = 0; p < 64; p++) m_free[p] = (p != 0);
      for (int a = 0; a < 32; a++) begin m_spec[a] = m_ret[a]; m_free[m_ret[a]] = 1'b0; end
      m_ov = 2'b00;
    end else if (m_ov == 2'b00 || out_ready) begin
      m_ov = acc ? in_valid : 2'b00;
      if (acc) begin sb.push_back(g); loaded = 1'b1; end
    end
    @(posedge clk);
    #1;
    check_val("out_valid", {30'd0, out_valid}, {30'd0, m_ov});
    check_val("free_cnt", {25'd0, free_cnt}, m_cnt());
    if (loaded) begin
      if (sb.size() == 0) begin
        check_val("sb_empty", 32'd1, 32'd0);
      end else begin
        got = sb.pop_front();
        check_val("grp_ps1", {20'd0, out_ps1}, {20'd0, got.ps1});
        check_val("grp_ps2", {20'd0, out_ps2}, {20'd0, got.ps2});
        check_val("grp_pd", {20'd0, out_pd}, {20'd0, got.pd});
        check_val("grp_old", {20'd0, out_old_pd}, {20'd0, got.old});
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    res = 1'b1;
    clear_in();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_val("rst_out_valid", {30'd0, out_valid}, 32'd0);
    check_val("rst_out_pd", {20'd0, out_pd | out_ps1 | out_ps2 | out_old_pd}, 32'd0);
    check_val("rst_free_cnt", {25'd0, free_cnt}, 32'd32);
    @(negedge clk);
    res = 1'b0;
  endtask

  initial begin
    res = 1'b1;
    clear_in();
    out_ready = 1'b1;
    @(negedge clk);

    // Intra-group RAW and WAW bypass
    do_reset();
    set_lane(0, 1'b1, 1, 2, 3); set_lane(1, 1'b1, 3, 0, 3);
    tick();
    check_val("t1_pd0", {26'd0, out_pd[5:0]}, 32'd32);
    check_val("t1_old0", {26'd0, out_old_pd[5:0]}, 32'd3);
    check_val("t1_ps1_1", {26'd0, out_ps1[11:6]}, 32'd32);
    check_val("t1_pd1", {26'd0, out_pd[11:6]}, 32'd33);
    check_val("t1_old1", {26'd0, out_old_pd[11:6]}, 32'd32);
    check_val("t1_free", {25'd0, free_cnt}, 32'd30);
    clear_in(); set_lane(0, 1'b0, 3, 0, 0);
    tick();
    check_val("t1_follow", {26'd0, out_ps1[5:0]}, 32'd33);

    // Store lane and rd=0 lane consume nothing
    do_reset();
    set_lane(0, 1'b1, 0, 0, 5); set_lane(1, 1'b0, 1, 2, 6);
    tick();
    check_val("t2_pd0", {26'd0, out_pd[5:0]}, 32'd32);
    check_val("t2_pd1", {26'd0, out_pd[11:6]}, 32'd0);
    check_val("t2_free", {25'd0, free_cnt}, 32'd31);
    clear_in(); set_lane(0, 1'b1, 0, 5, 0);
    tick();
    check_val("t2_rd0_pd", {26'd0, out_pd[5:0]}, 32'd0);
    check_val("t2_rd0_free", {25'd0, free_cnt}, 32'd31);
    clear_in(); set_lane(0, 1'b0, 0, 0, 0);
    tick();
    check_val("t2_rat0", {26'd0, out_ps1[5:0]}, 32'd0);

    // Exhaust free list, then refill through commits
    do_reset();
    for (int n = 0; n < 16; n++) begin
      clear_in(); set_lane(0, 1'b1, 1, 2, 1); set_lane(1, 1'b1, 2, 1, 2);
      tick();
    end
    clear_in();
    #1;
    check_val("t3_empty", {25'd0, free_cnt}, 32'd0);
    check_val("t3_notready", {31'd0, in_ready}, 32'd0);
    set_lane(0, 1'b1, 0, 0, 4);
    set_commit(0, 1, 32, 7);
    tick();
    check_val("t3_one", {25'd0, free_cnt}, 32'd1);
    clear_in(); set_commit(0, 2, 33, 9);
    tick();
    clear_in(); set_lane(0, 1'b1, 0, 0, 1); set_lane(1, 1'b1, 0, 0, 2);
    tick();
    check_val("t3_reuse0", {26'd0, out_pd[5:0]}, 32'd7);
    check_val("t3_reuse1", {26'd0, out_pd[11:6]}, 32'd9);

    // Backpressure: output held stable, pending group follows release
    do_reset();
    set_lane(0, 1'b1, 1, 2, 3);
    out_ready = 1'b0;
    tick();
    snap = out_pd;
    clear_in(); set_lane(0, 1'b1, 3, 0, 4);
    for (int n = 0; n < 3; n++) begin
      tick();
      check_val("t4_hold_pd", {20'd0, out_pd}, {20'd0, snap});
      check_val("t4_hold_free", {25'd0, free_cnt}, 32'd31);
    end
    out_ready = 1'b1;
    tick();
    check_val("t4_rel_pd", {26'd0, out_pd[5:0]}, 32'd33);
    check_val("t4_rel_ps1", {26'd0, out_ps1[5:0]}, 32'd32);

    // Commit then flush restores the committed mapping
    do_reset();
    set_lane(0, 1'b1, 0, 0, 3); set_lane(1, 1'b1, 0, 0, 4);
    tick();
    clear_in(); set_lane(0, 1'b1, 0, 0, 3);
    tick();
    check_val("t5_pd34", {26'd0, out_pd[5:0]}, 32'd34);
    clear_in(); set_commit(0, 3, 32, 3); set_commit(1, 4, 33, 4);
    tick();
    clear_in(); flush = 1'b1; set_lane(0, 1'b1, 3, 4, 5);
    tick();
    check_val("t5_free", {25'd0, free_cnt}, 32'd32);
    check_val("t5_ov", {30'd0, out_valid}, 32'd0);
    clear_in(); set_lane(0, 1'b0, 3, 4, 0);
    tick();
    check_val("t5_ps1", {26'd0, out_ps1[5:0]}, 32'd32);
    check_val("t5_ps2", {26'd0, out_ps2[5:0]}, 32'd33);

    // Reset mid-stream with a valid output
    clear_in(); set_lane(0, 1'b1, 1, 1, 3); set_lane(1, 1'b1, 2, 2, 4);
    tick();
    do_reset();
    set_lane(0, 1'b0, 3, 4, 0);
    tick();
    check_val("t6_id_ps1", {26'd0, out_ps1[5:0]}, 32'd3);
    check_val("t6_id_ps2", {26'd0, out_ps2[5:0]}, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rename_unit.md
# rename_unit

Parametrised register-rename stage for the out-of-order pipeline, sitting between ID and the reservation stations / ROB. Each cycle it renames a group of up to WIDTH instructions: sources are translated through a speculative alias table, destinations get free physical registers, and intra-group dependencies are bypassed. A retirement alias table, updated by ROB commits, allows a one-cycle flush that restores the committed mapping and rebuilds the free list.

## Interface
- ARCH_ADDR_W, 5, architectural register address width; NUM_ARCH = 2**ARCH_ADDR_W
- PHYS_ADDR_W, 6, physical register address width; NUM_PHYS = 2**PHYS_ADDR_W; NUM_PHYS > NUM_ARCH required
- WIDTH, 2, rename lanes per cycle (lane 0 is oldest)
- RETIRE, 2, commit ports per cycle
- clk  in  1  clock, all state updates on posedge
- res  in  1  synchronous, active-high reset
- in_valid  in  WIDTH  lane holds a valid instruction
- in_has_rd  in  WIDTH  lane writes a destination (0 for stores/branches)
- in_rs1, in_rs2, in_rd  in  WIDTH*ARCH_ADDR_W  architectural sources/destination, lane i at bits [i*ARCH_ADDR_W +: ARCH_ADDR_W]
- in_ready  out  1  group accepted on a posedge where in_ready & |in_valid
- out_valid  out  WIDTH  renamed lane valid (registered)
- out_ps1, out_ps2, out_pd, out_old_pd  out  WIDTH*PHYS_ADDR_W  physical sources, new destination, previous mapping of rd (handed to ROB for later freeing)
- out_ready  in  1  downstream (RS/ROB) accepts the output group
- commit_valid  in  RETIRE  ROB retires an instruction with a destination
- commit_rd  in  RETIRE*ARCH_ADDR_W  retired architectural destination
- commit_pd, commit_old_pd  in  RETIRE*PHYS_ADDR_W  retired new mapping / mapping to free
- flush  in  1  restore speculative state from retirement state
- free_cnt  out  PHYS_ADDR_W+1  current number of free physical registers

## Operation
- State: spec RAT[NUM_ARCH], retire RAT[NUM_ARCH], free bit vector[NUM_PHYS], output register.
- Reset: both RATs identity (RAT[i]=i); phys 0..NUM_ARCH-1 busy, rest free; free_cnt = NUM_PHYS-NUM_ARCH; all out_* = 0; in_ready = 0 while res is high.
- Arch reg 0 hardwired: in_rd=0 treated as in_has_rd=0; RAT[0] stays 0; phys 0 never freed or allocated.
- in_ready = !res & !flush & !(|out_valid & !out_ready) & (free_cnt >= WIDTH); independent of in_valid (no combinational loop).
- Allocation: lanes with valid & has_rd take free registers lowest index first, in lane order; non-allocating lanes output out_pd = 0, out_old_pd = 0 and consume nothing.
- Source translation: lane j source takes the out_pd of the youngest lane i<j that is valid, has_rd and has rd equal to that source; otherwise spec RAT. Source arch 0 always maps to phys 0.
- out_old_pd: same bypass rule applied to rd (WAW within a group); otherwise spec RAT[rd].
- Spec RAT write: youngest lane wins for an rd duplicated within a group.
- Commit: for each commit_valid port, retire RAT[commit_rd] <= commit_pd and free[commit_old_pd] <= 1. Ports retire in order; a later port wins for the same rd.
- Flush: spec RAT <= retire RAT including same-cycle commits; free[p] <= 1 iff p is not referenced by the post-commit retire RAT and p != 0; out_valid <= 0; no group is accepted.
- free_cnt tracks the free vector exactly: allocations subtract, commit frees add, flush recomputes.

## Timing
- Rename latency is 1 cycle: a group accepted at edge N appears on out_* after edge N.
- The output register holds stable while |out_valid & !out_ready; it loads a new group, or clears to out_valid=0 when nothing is accepted, whenever out_ready or !|out_valid.
- A freed register becomes allocatable on the cycle after the commit edge; it is never reused in the same cycle.
- Flush has priority over rename in the same cycle. Commits are applied in the same cycle as flush. Reset has priority over everything.
- Simultaneous allocation and commit in one cycle is legal: free_cnt(next) = free_cnt - allocated + freed.

## Test plan
- After reset, lane0 (rs1=1, rs2=2, rd=3) and lane1 (rs1=3, rs2=0, rd=3) -> lane0 ps1=1 ps2=2 pd=32 old=3; lane1 ps1=32 ps2=0 pd=33 old=32; a following group reading rs1=3 gets 33; free_cnt=30.
- Lane0 rd=5, lane1 a store (has_rd=0) -> lane0 pd=32, lane1 pd=0 old=0, free_cnt=31. Lane with rd=0 -> pd=0, RAT[0] unchanged.
- 16 groups of two destinations -> free_cnt=0 and in_ready=0. Commit freeing old_pd=7 -> free_cnt=1, still not ready. Second commit freeing 9 -> ready; the next group gets pd 7 then 9.
- Hold out_ready=0 for 3 cycles with a valid output -> out_* stable, in_ready=0, free_cnt unchanged. Release -> the pending input group appears the next cycle.
- Rename rd=3 (->32) and rd=4 (->33), then rd=3 (->34). Commit the first two, then flush -> free_cnt=32; a group reading rs1=3, rs2=4 gets 32, 33; out_valid=0 in the cycle after the flush.
- Assert res mid-stream with out_valid high -> next cycle all outputs 0, identity RAT, free_cnt=32.
